// File: rtl/mem_row_streamer.sv
// -----------------------------------------------------------------------------
// mem_row_streamer
//
// Streams rows 0..num_rows-1 out of an attached simple dual-port memory
// (read port B, fixed read latency LATENCY with enb held high) onto a
// valid/ready stream. Reads are issued ahead into a small skid FIFO so the
// stream sustains one beat per cycle and never drops data under backpressure.
//
// Optional feature: define STREAMER_STATS_EN to count backpressure cycles
// (out_valid=1, out_ready=0) in stall_cycles. Without it stall_cycles is 0.
//
// Ports
//   clk          in   single clock, rising edge
//   rst_n        in   synchronous active-low reset
//   start        in   one-cycle stream request (ignored while busy)
//   num_rows     in   row count, sampled when start is accepted
//   enb          out  memory read enable (high whenever out of reset)
//   addrb        out  memory read address
//   doutb        in   memory read data, LATENCY cycles after address
//   out_data     out  streamed row
//   out_valid    out  out_data valid
//   out_ready    in   consumer ready
//   out_last     out  final beat of the stream
//   busy         out  stream in progress
//   done         out  one-cycle completion pulse
//   stall_cycles out  backpressure cycle counter (saturating)
// -----------------------------------------------------------------------------
module mem_row_streamer #(
    parameter int DEPTH       = 169,
    parameter int DATA_WIDTH  = 32,
    parameter int LATENCY     = 2,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int FIFO_DEPTH = LATENCY + 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_rows,
    output logic                  enb,
    output logic [ADDR_WIDTH-1:0] addrb,
    input  logic [DATA_WIDTH-1:0] doutb,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  busy,
    output logic                  done,
    output logic [31:0]           stall_cycles
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [CNT_W:0]      OCC_LIMIT = (CNT_W + 1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] ROWS_MAX  = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] ROW_ONE   = (ADDR_WIDTH + 1)'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                  state_reg, state_next;
    logic                    enb_reg;
    logic                    zero_done_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [ADDR_WIDTH:0]     num_rows_reg;
    logic [ADDR_WIDTH:0]     beat_cnt_reg;
    logic [LATENCY-1:0]      vld_reg;
    logic [LATENCY-1:0]      vld_next;
    logic [DATA_WIDTH-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]        wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]        count_reg;

    logic                    accept, issue, stream_done;
    logic                    push, pop, credit;
    logic                    addr_at_last, last_beat;
    logic [ADDR_WIDTH:0]     rows_m1, rows_in;
    logic [CNT_W-1:0]        pending_cnt;
    logic [CNT_W:0]          occupancy;

    // Rows beyond the memory depth would never reach a last address, so clamp.
    assign rows_in      = (num_rows > ROWS_MAX) ? ROWS_MAX : num_rows;
    assign rows_m1      = num_rows_reg - ROW_ONE;
    assign addr_at_last = ({1'b0, addr_reg} == rows_m1);
    assign last_beat    = (beat_cnt_reg == rows_m1);

    assign push = vld_reg[LATENCY-1];
    assign pop  = out_valid && out_ready;

    // Reads in flight plus buffered beats must never exceed the FIFO size;
    // a pop in the current cycle is deliberately not credited, which keeps
    // the check off the out_ready path while still sustaining full rate.
    always_comb begin
        pending_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            pending_cnt = pending_cnt + CNT_W'(vld_reg[i]);
        end
    end

    assign occupancy = {1'b0, pending_cnt} + {1'b0, count_reg};
    assign credit    = (occupancy < OCC_LIMIT);

    // Valid shift register: bit gi marks a read issued gi+1 cycles ago.
    assign vld_next[0] = issue;
    generate
        for (genvar gi = 1; gi < LATENCY; gi++) begin : g_vld_shift
            assign vld_next[gi] = vld_reg[gi-1];
        end
    endgenerate

    // Next-state and control decode.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        issue       = 1'b0;
        stream_done = 1'b0;
        case (state_reg)
            IDLE: begin
                // The zero-row done pulse still counts as busy.
                if (start && !zero_done_reg) begin
                    accept = 1'b1;
                    if (num_rows != '0) begin
                        state_next = ISSUE;
                    end
                end
            end
            ISSUE: begin
                if (credit) begin
                    issue = 1'b1;
                    if (addr_at_last) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && last_beat) begin
                    stream_done = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            enb_reg       <= 1'b0;
            zero_done_reg <= 1'b0;
            addr_reg      <= '0;
            num_rows_reg  <= '0;
            beat_cnt_reg  <= '0;
            vld_reg       <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            enb_reg       <= 1'b1;
            zero_done_reg <= accept && (num_rows == '0);
            vld_reg       <= vld_next;

            if (accept) begin
                num_rows_reg <= rows_in;
                addr_reg     <= '0;
                beat_cnt_reg <= '0;
            end else begin
                // Address parks on the last row once it has been issued.
                if (issue && !addr_at_last) begin
                    addr_reg <= addr_reg + 1'b1;
                end
                if (pop) begin
                    beat_cnt_reg <= beat_cnt_reg + ROW_ONE;
                end
            end

            if (push) begin
                wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

    // FIFO storage holds data only; occupancy is tracked by count_reg.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_reg] <= doutb;
        end
    end

`ifdef STREAMER_STATS_EN
    logic [31:0] stall_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_reg <= '0;
        end else if (accept) begin
            stall_reg <= '0;
        end else if (out_valid && !out_ready && (stall_reg != '1)) begin
            stall_reg <= stall_reg + 32'd1;
        end
    end

    assign stall_cycles = stall_reg;
`else
    assign stall_cycles = '0;
`endif

    assign enb       = enb_reg;
    assign addrb     = addr_reg;
    assign out_valid = (count_reg != '0);
    assign out_data  = out_valid ? fifo_mem[rd_ptr_reg] : '0;
    assign out_last  = out_valid && last_beat;
    assign busy      = (state_reg != IDLE) || zero_done_reg;
    assign done      = stream_done || zero_done_reg;

endmodule
